// File: rtl/mult.sv
// ============================================================================
//  Module      : mult
//  Description : Sequential radix-2 shift-add multiplier for the MIPS HI/LO
//                unit (MULT / MULTU). Multiplies operand magnitudes, then
//                applies the sign to the 64-bit product on completion.
//                Optional build macro MULT_EARLY_TERM_EN: leave the
//                iteration loop as soon as the remaining multiplier is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signmul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_load;
    logic               w_iterate;
    logic               w_finish;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_result;

    // Magnitudes: 0x80000000 negates to itself, which read unsigned is 2^31.
    assign w_mag_a  = (signmul && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    assign w_mag_b  = (signmul && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
    assign w_result = r_neg ? (~r_acc) + (2*WIDTH)'(1) : r_acc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_iterate   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_BUSY;
                end
            end
            c_BUSY: begin
`ifdef MULT_EARLY_TERM_EN
                // No set bits left in the multiplier: acc already holds the product.
                if (r_mplier == '0) begin
                    w_state_nxt = c_FINISH;
                end else begin
                    w_iterate = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = c_FINISH;
                    end
                end
`else
                w_iterate = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_FINISH;
                end
`endif
            end
            c_FINISH: begin
                w_finish    = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_neg    <= signmul & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_acc    <= '0;
                r_cnt    <= '0;
            end
            if (w_iterate) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end
            if (w_finish) begin
                r_hi <= w_result[2*WIDTH-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;
    assign busy = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult.sv
// ============================================================================
//  Module      : tb_mult
//  Description : Self-checking bench for mult. A cycle-level reference model
//                predicts busy/done/{hi,lo} from operand arithmetic and the
//                documented latency; directed vectors pin literal values.
//                Honours MULT_EARLY_TERM_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signmul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

`ifdef MULT_EARLY_TERM_EN
    localparam bit c_ET = 1'b1;
`else
    localparam bit c_ET = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mult #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .signmul (signmul),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_product(logic [31:0] x, logic [31:0] y, logic s);
        longint      sx;
        longint      sy;
        logic [63:0] ux;
        logic [63:0] uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int latency(logic [31:0] y, logic s);
        logic [31:0] m;
        int          k;
        if (!c_ET) return 33;
        m = (s && y[31]) ? (32'd0 - y) : y;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return (k + 2 > 33) ? 33 : k + 2;
    endfunction

    int          m_left;
    logic [63:0] m_pend;
    logic [63:0] m_prod;
    logic        m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_pend <= '0;
            m_prod <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_pend <= ref_product(a, b, signmul);
                    m_left <= latency(b, signmul);
                end
            end else if (m_left == 1) begin
                m_prod <= m_pend;
                m_done <= 1'b1;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, (m_left != 0)});
        chk("done", {63'd0, done}, {63'd0, m_done});
        chk("product", {hi, lo}, m_prod);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 100);
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
        @(posedge clk);
        #1;
        a = x; b = y; signmul = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s, output int lat);
        launch(x, y, s);
        wait_done(lat);
    endtask

    task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                            input logic s, input logic [63:0] exp, input int exp_lat);
        int lat;
        do_op(x, y, s, lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_val"}, {hi, lo}, exp);
    endtask

    initial begin
        int          lat;
        int          dseen;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rs;

        rst = 1'b1; start = 1'b0; signmul = 1'b0; a = '0; b = '0;
        #3;
        chk("reset_outputs", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Model pins
        chk("pin_neg3x7", ref_product(32'hFFFFFFFD, 32'd7, 1'b1), 64'hFFFFFFFF_FFFFFFEB);
        chk("pin_umax", ref_product(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE_00000001);

        // Directed vectors
        directed("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 33);
        directed("neg3x7", 32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB, c_ET ? 5 : 33);
        directed("minxmin", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 33);
        directed("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, c_ET ? 3 : 33);
        directed("b0", 32'h1234, 32'd0, 1'b0, 64'd0, c_ET ? 2 : 33);
        directed("b1", 32'h1234, 32'd1, 1'b0, 64'h1234, c_ET ? 3 : 33);

        // Async reset between edges clears outputs immediately
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out", {hi, lo}, 64'd0);
        chk("async_rst_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // start during BUSY is ignored
        launch(32'd3, 32'hFFFFFFFF, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        a = 32'd9; b = 32'd9; signmul = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        chk("ignored_lat", 64'(lat), 64'd28);
        chk("ignored_val", {hi, lo}, 64'h00000002_FFFFFFFD);

        // Back-to-back: second start in the done cycle
        do_op(32'hFFFFFFFD, 32'd7, 1'b1, lat);
        a = 32'h1234; b = 32'h10; signmul = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_hold", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        wait_done(lat);
        chk("b2b_lat", 64'(lat), c_ET ? 64'd7 : 64'd33);
        chk("b2b_val", {hi, lo}, 64'h12340);

        // Reset mid-operation aborts
        launch(32'd7, 32'hFFFFFFFF, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out", {hi, lo}, 64'd0);
        chk("abort_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dseen++;
        end
        chk("abort_no_done", 64'(dseen), 64'd0);

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = ry >> $urandom_range(0, 31);
                1: rx = 32'h80000000;
                2: ry = 32'h80000000;
                3: ry = 32'($urandom_range(0, 3));
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            do_op(rx, ry, rs, lat);
            chk("rand_lat", 64'(lat), 64'(latency(ry, rs)));
            chk("rand_val", {hi, lo}, ref_product(rx, ry, rs));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
